// File: rtl/car_park_occupancy_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// car_park_occupancy_ctrl_if : gate sensor inputs and occupancy status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface car_park_occupancy_ctrl_if #(
  parameter int N_GATES = 2,
  parameter int CNT_W   = 4
);
  logic [N_GATES-1:0] a;
  logic [N_GATES-1:0] b;
  logic [N_GATES-1:0] enter;
  logic [N_GATES-1:0] exit;
  logic [N_GATES-1:0] gate_timeout;
  logic [CNT_W-1:0]   car_count;
  logic [CNT_W-1:0]   spaces;
  logic               full;
  logic               empty;
  logic               ovf_err;
  logic               udf_err;

  modport master (
    output a, b,
    input  enter, exit, gate_timeout, car_count, spaces,
    input  full, empty, ovf_err, udf_err
  );

  modport slave (
    input  a, b,
    output enter, exit, gate_timeout, car_count, spaces,
    output full, empty, ovf_err, udf_err
  );
endinterface
`default_nettype wire

// File: rtl/car_park_occupancy_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// car_park_occupancy_ctrl : per-gate direction FSMs feeding a saturating count
// Optional macro GATE_TIMEOUT_EN adds a per-gate stuck-sequence abort. Rev 1.0
// ---------------------------------------------------------------------------
module car_park_occupancy_ctrl #(
  parameter int N_GATES     = 2,
  parameter int CAPACITY    = 12,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  car_park_occupancy_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] IN1  = 3'd1;
  localparam logic [2:0] IN2  = 3'd2;
  localparam logic [2:0] IN3  = 3'd3;
  localparam logic [2:0] OUT1 = 3'd4;
  localparam logic [2:0] OUT2 = 3'd5;
  localparam logic [2:0] OUT3 = 3'd6;

  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [N_GATES-1:0] enter_v;
  logic [N_GATES-1:0] exit_v;
  logic [N_GATES-1:0] tmo_v;

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] ab;
    logic       enter_r;
    logic       exit_r;
    logic       enter_nxt;
    logic       exit_nxt;
    logic       tmo;

    assign ab = {bus.a[g], bus.b[g]};

`ifdef GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer;
    logic          tmo_r;

    // tmo fires on the edge that would take the timer to TIMEOUT_CYC
    assign tmo = (state != IDLE) && (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        timer <= '0;
        tmo_r <= 1'b0;
      end else begin
        tmo_r <= tmo;
        if ((state == IDLE) || tmo) timer <= '0;
        else                        timer <= timer + 1'b1;
      end
    end

    assign tmo_v[g] = tmo_r;
`else
    assign tmo      = 1'b0;
    assign tmo_v[g] = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= IDLE;
        enter_r <= 1'b0;
        exit_r  <= 1'b0;
      end else begin
        state   <= state_nxt;
        enter_r <= enter_nxt;
        exit_r  <= exit_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE: begin
          if (ab == 2'b10)      state_nxt = IN1;
          else if (ab == 2'b01) state_nxt = OUT1;
        end
        IN1: begin
          if (ab == 2'b11)      state_nxt = IN2;
          else if (ab == 2'b00) state_nxt = IDLE;
        end
        IN2: begin
          if (ab == 2'b01)      state_nxt = IN3;
          else if (ab == 2'b10) state_nxt = IN1;
          else if (ab == 2'b00) state_nxt = IDLE;
        end
        IN3: begin
          if (ab == 2'b00)      state_nxt = IDLE;
          else if (ab == 2'b11) state_nxt = IN2;
          else if (ab == 2'b10) state_nxt = IN1;
        end
        OUT1: begin
          if (ab == 2'b11)      state_nxt = OUT2;
          else if (ab == 2'b00) state_nxt = IDLE;
        end
        OUT2: begin
          if (ab == 2'b10)      state_nxt = OUT3;
          else if (ab == 2'b01) state_nxt = OUT1;
          else if (ab == 2'b00) state_nxt = IDLE;
        end
        OUT3: begin
          if (ab == 2'b00)      state_nxt = IDLE;
          else if (ab == 2'b11) state_nxt = OUT2;
          else if (ab == 2'b01) state_nxt = OUT1;
        end
        default:                state_nxt = IDLE;
      endcase
      if (tmo) state_nxt = IDLE;
    end

    always_comb begin
      enter_nxt = (state == IN3)  && (ab == 2'b00) && !tmo;
      exit_nxt  = (state == OUT3) && (ab == 2'b00) && !tmo;
    end

    assign enter_v[g] = enter_r;
    assign exit_v[g]  = exit_r;
  end

  logic [CNT_W-1:0]       count;
  logic                   ovf;
  logic                   udf;
  logic signed [SW-1:0]   net;
  logic signed [SW-1:0]   sum;

  // Wide signed sum so several simultaneous events never wrap before the clamp
  always_comb begin
    net = '0;
    for (int g = 0; g < N_GATES; g++) begin
      net = net + SW'(enter_v[g]) - SW'(exit_v[g]);
    end
    sum = $signed({4'b0000, count}) + net;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      ovf <= (sum > CAP_S);
      udf <= sum[SW-1];
      if (sum[SW-1])        count <= '0;
      else if (sum > CAP_S) count <= CNT_W'(CAPACITY);
      else                  count <= sum[CNT_W-1:0];
    end
  end

  assign bus.enter        = enter_v;
  assign bus.exit         = exit_v;
  assign bus.gate_timeout = tmo_v;
  assign bus.car_count    = count;
  assign bus.spaces       = CNT_W'(CAPACITY) - count;
  assign bus.full         = (count == CNT_W'(CAPACITY));
  assign bus.empty        = (count == '0);
  assign bus.ovf_err      = ovf;
  assign bus.udf_err      = udf;

endmodule
`default_nettype wire

// File: tb/tb_car_park_occupancy_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_car_park_occupancy_ctrl : vector table, corner sequences and random run
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_car_park_occupancy_ctrl;
  localparam int NG  = 2;
  localparam int CAP = 12;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  car_park_occupancy_ctrl_if #(.N_GATES(NG), .CNT_W(CW)) bus ();

  car_park_occupancy_ctrl #(
    .N_GATES(NG), .CAPACITY(CAP), .CNT_W(CW), .TIMEOUT_CYC(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: each gate is a direction (+1 in, -1 out, 0 idle) and a
  // progress stage 1..3 along that direction's beam pattern sequence.
  int           dir [NG];
  int           stg [NG];
  logic [NG-1:0] men, mex;
  int           mcount;
  logic         movf, mudf;

  function automatic int pos(input int d, input logic [1:0] p);
    if (p == 2'b11) return 2;
    if ((d > 0) == (p == 2'b10)) return 1;
    return 3;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin dir[g] = 0; stg[g] = 0; end
    men = '0; mex = '0; mcount = 0; movf = 1'b0; mudf = 1'b0;
  endtask

  task automatic model_edge(input logic [NG-1:0] av, input logic [NG-1:0] bv);
    int s;
    logic [1:0] p;
    int k;
    s = mcount + $countones(men) - $countones(mex);
    movf = (s > CAP);
    mudf = (s < 0);
    mcount = (s > CAP) ? CAP : ((s < 0) ? 0 : s);
    men = '0; mex = '0;
    for (int g = 0; g < NG; g++) begin
      p = {av[g], bv[g]};
      if (p == 2'b00) begin
        if (dir[g] > 0 && stg[g] == 3) men[g] = 1'b1;
        if (dir[g] < 0 && stg[g] == 3) mex[g] = 1'b1;
        dir[g] = 0; stg[g] = 0;
      end else if (dir[g] == 0) begin
        if (p == 2'b10)      begin dir[g] = 1;  stg[g] = 1; end
        else if (p == 2'b01) begin dir[g] = -1; stg[g] = 1; end
      end else begin
        k = pos(dir[g], p);
        if (!(stg[g] == 1 && k == 3)) stg[g] = k;
      end
    end
  endtask

  task automatic model_check();
    chk("m_enter",   bus.enter,     men);
    chk("m_exit",    bus.exit,      mex);
    chk("m_count",   bus.car_count, mcount);
    chk("m_spaces",  bus.spaces,    CAP - mcount);
    chk("m_full",    bus.full,      mcount == CAP);
    chk("m_empty",   bus.empty,     mcount == 0);
    chk("m_ovf",     bus.ovf_err,   movf);
    chk("m_udf",     bus.udf_err,   mudf);
    chk("m_timeout", bus.gate_timeout, 0);
  endtask

  task automatic step(input logic [NG-1:0] av, input logic [NG-1:0] bv);
    bus.a = av;
    bus.b = bv;
    @(posedge clk);
    model_edge(av, bv);
    #1;
    model_check();
  endtask

  // Drive one gate through a full entry or exit sequence, others idle
  task automatic gate_seq(input int g, input bit entry);
    logic [NG-1:0] av, bv;
    logic [1:0] pat [4];
    pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      av = '0; bv = '0;
      av[g] = entry ? pat[i][1] : pat[i][0];
      bv[g] = entry ? pat[i][0] : pat[i][1];
      step(av, bv);
    end
  endtask

  typedef struct {
    logic [NG-1:0] a;
    logic [NG-1:0] b;
    logic [NG-1:0] en;
    logic [NG-1:0] ex;
    int            cnt;
  } vec_t;

  vec_t tbl [23];

  initial begin
    // gate0 entry
    tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 0};
    tbl[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 0};
    tbl[2]  = '{2'b01, 2'b01, 2'b00, 2'b00, 0};
    tbl[3]  = '{2'b00, 2'b01, 2'b00, 2'b00, 0};
    tbl[4]  = '{2'b00, 2'b00, 2'b01, 2'b00, 0};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1};
    // gate0 aborted: 10,11,10,00
    tbl[7]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1};
    tbl[8]  = '{2'b01, 2'b01, 2'b00, 2'b00, 1};
    tbl[9]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 1};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 1};
    // both gates enter together: +2
    tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b00, 1};
    tbl[13] = '{2'b11, 2'b11, 2'b00, 2'b00, 1};
    tbl[14] = '{2'b00, 2'b11, 2'b00, 2'b00, 1};
    tbl[15] = '{2'b00, 2'b00, 2'b11, 2'b00, 1};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 3};
    // gate1 exit at count 3
    tbl[17] = '{2'b00, 2'b10, 2'b00, 2'b00, 3};
    tbl[18] = '{2'b10, 2'b10, 2'b00, 2'b00, 3};
    tbl[19] = '{2'b10, 2'b00, 2'b00, 2'b00, 3};
    tbl[20] = '{2'b00, 2'b00, 2'b00, 2'b10, 3};
    tbl[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 2};
    tbl[22] = '{2'b00, 2'b00, 2'b00, 2'b00, 2};

    rst = 1'b0;
    bus.a = '0;
    bus.b = '0;
    model_reset();
    #3;
    chk("rst_count",  bus.car_count, 0);
    chk("rst_spaces", bus.spaces,    CAP);
    chk("rst_full",   bus.full,      0);
    chk("rst_empty",  bus.empty,     1);
    chk("rst_enter",  bus.enter,     0);
    chk("rst_exit",   bus.exit,      0);
    chk("rst_ovf",    bus.ovf_err,   0);
    chk("rst_udf",    bus.udf_err,   0);
    #4;
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].a, tbl[i].b);
      chk("tbl_enter",  bus.enter,     tbl[i].en);
      chk("tbl_exit",   bus.exit,      tbl[i].ex);
      chk("tbl_count",  bus.car_count, tbl[i].cnt);
      chk("tbl_spaces", bus.spaces,    CAP - tbl[i].cnt);
      chk("tbl_empty",  bus.empty,     tbl[i].cnt == 0);
    end

    // count 2 -> 5, then simultaneous entry on gate0 and exit on gate1
    for (int i = 0; i < 3; i++) begin gate_seq(0, 1'b1); step(2'b00, 2'b00); end
    step(2'b00, 2'b00);
    chk("pre_sim_count", bus.car_count, 5);
    step(2'b01, 2'b10);
    step(2'b11, 2'b11);
    step(2'b10, 2'b01);
    step(2'b00, 2'b00);
    chk("sim_enter", bus.enter, 2'b01);
    chk("sim_exit",  bus.exit,  2'b10);
    step(2'b00, 2'b00);
    chk("sim_count", bus.car_count, 5);
    chk("sim_ovf",   bus.ovf_err,   0);

    // fill to capacity, then one entry too many
    for (int i = 0; i < 7; i++) begin gate_seq(0, 1'b1); step(2'b00, 2'b00); end
    chk("fill_count",  bus.car_count, CAP);
    chk("fill_full",   bus.full,      1);
    chk("fill_spaces", bus.spaces,    0);
    gate_seq(0, 1'b1);
    step(2'b00, 2'b00);
    chk("ovf_pulse", bus.ovf_err,   1);
    chk("ovf_count", bus.car_count, CAP);
    step(2'b00, 2'b00);
    chk("ovf_clear", bus.ovf_err,   0);

    // drain to zero, then one exit too many
    for (int i = 0; i < CAP; i++) begin gate_seq(1, 1'b0); step(2'b00, 2'b00); end
    chk("drain_empty", bus.empty, 1);
    gate_seq(1, 1'b0);
    step(2'b00, 2'b00);
    chk("udf_pulse", bus.udf_err,   1);
    chk("udf_count", bus.car_count, 0);
    step(2'b00, 2'b00);
    chk("udf_clear", bus.udf_err,   0);

    // asynchronous reset while gate0 sits in IN2 at count 7
    for (int i = 0; i < 7; i++) begin gate_seq(0, 1'b1); step(2'b00, 2'b00); end
    chk("pre_rst_count", bus.car_count, 7);
    step(2'b01, 2'b00);
    step(2'b01, 2'b01);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_count", bus.car_count, 0);
    chk("midrst_empty", bus.empty,     1);
    chk("midrst_enter", bus.enter,     0);
    #2;
    rst = 1'b1;
    step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    chk("postrst_enter", bus.enter,     0);
    chk("postrst_count", bus.car_count, 0);

    // random sensor activity against the model
    for (int i = 0; i < 1500; i++) begin
      step(NG'($urandom), NG'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
